rect_plotter: RTL and testbench

// Rasterises one rectangle per request into pixel writes for the VGA adapter,
// one pixel per clock. Sits directly downstream of the display mux. The mux

---
 rtl/rect_plotter_pkg.sv | 34 +++
 rtl/rect_plotter_xy_scan_counter.sv | 61 ++++++
 rtl/rect_plotter.sv | 181 ++++++++++++++++++
 tb/tb_rect_plotter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rect_plotter_pkg.sv
// Shared definitions for the rectangle plotter, the display mux and the game
// controller: screen geometry, coordinate/size/colour widths and the plotter
// FSM state encoding.
package rect_plotter_pkg;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned SIZE_W   = 5;
    localparam int unsigned COL_W    = 3;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [COL_W-1:0] BG_COLOUR = '0;

    // Screen limits at scan-counter width and at the one-bit-wider sum width.
    localparam logic [X_W-1:0] SCREEN_W_LIM = SCREEN_W[X_W-1:0];
    localparam logic [Y_W-1:0] SCREEN_H_LIM = SCREEN_H[Y_W-1:0];
    localparam logic [X_W:0]   SCREEN_W_EXT = SCREEN_W[X_W:0];
    localparam logic [Y_W:0]   SCREEN_H_EXT = SCREEN_H[Y_W:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAW   = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // True when an unwrapped pixel coordinate lies on the visible screen.
    function automatic logic in_screen(input logic [X_W:0] x, input logic [Y_W:0] y);
        return (x < SCREEN_W_EXT) && (y < SCREEN_H_EXT);
    endfunction

endpackage

// File: rtl/rect_plotter_xy_scan_counter.sv
// Row-major 2-D scan counter shared by rectangle draw and screen clear.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   load            restart the scan at (0,0)
//   enable          advance one position this cycle
//   limit_w/limit_h scan extent (width, height); must be non-zero while enabled
//   dx, dy          current offset within the scan
//   last            current position is (limit_w-1, limit_h-1)
module xy_scan_counter
    import rect_plotter_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           enable,
    input  logic [X_W-1:0] limit_w,
    input  logic [Y_W-1:0] limit_h,
    output logic [X_W-1:0] dx,
    output logic [Y_W-1:0] dy,
    output logic           last
);

    logic [X_W-1:0] dx_q, dx_d;
    logic [Y_W-1:0] dy_q, dy_d;
    logic           row_end;
    logic           col_end;

    always_comb begin
        row_end = (dx_q == limit_w - X_W'(1));
        col_end = (dy_q == limit_h - Y_W'(1));
        last    = row_end && col_end;

        dx_d = dx_q;
        dy_d = dy_q;
        if (load) begin
            dx_d = '0;
            dy_d = '0;
        end else if (enable) begin
            if (row_end) begin
                dx_d = '0;
                dy_d = col_end ? '0 : dy_q + Y_W'(1);
            end else begin
                dx_d = dx_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx = dx_q;
    assign dy = dy_q;

endmodule

// File: rtl/rect_plotter.sv
// Rasterises one rectangle per request into single-pixel VGA adapter writes,
// one pixel per clock, with clipping at the screen edge; also provides a
// full-screen clear to BG_COLOUR.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, clear               requests, sampled only when idle (clear wins)
//   rect_x/y/w/h/colour        rectangle operands, latched on acceptance
//   busy                       request in progress (through the done cycle)
//   done                       one-cycle completion pulse
//   vga_x, vga_y, vga_colour   registered pixel write data (held when plot=0)
//   plot                       registered pixel write enable
module rect_plotter
    import rect_plotter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic [X_W-1:0]    rect_x,
    input  logic [Y_W-1:0]    rect_y,
    input  logic [SIZE_W-1:0] rect_w,
    input  logic [SIZE_W-1:0] rect_h,
    input  logic [COL_W-1:0]  rect_colour,
    output logic              busy,
    output logic              done,
    output logic [X_W-1:0]    vga_x,
    output logic [Y_W-1:0]    vga_y,
    output logic [COL_W-1:0]  vga_colour,
    output logic              plot
);

    state_t state_q, state_d;

    logic [X_W-1:0]    x0_q,  x0_d;
    logic [Y_W-1:0]    y0_q,  y0_d;
    logic [SIZE_W-1:0] w_q,   w_d;
    logic [SIZE_W-1:0] h_q,   h_d;
    logic [COL_W-1:0]  col_q, col_d;

    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              plot_q,    plot_d;
    logic [X_W-1:0]    vga_x_q,   vga_x_d;
    logic [Y_W-1:0]    vga_y_q,   vga_y_d;
    logic [COL_W-1:0]  vga_col_q, vga_col_d;

    logic              scan_load;
    logic              scan_en;
    logic [X_W-1:0]    limit_w;
    logic [Y_W-1:0]    limit_h;
    logic [X_W-1:0]    dx;
    logic [Y_W-1:0]    dy;
    logic              scan_last;

    logic [X_W:0]      sum_x;
    logic [Y_W:0]      sum_y;

    xy_scan_counter u_scan (
        .clk     (clk),
        .reset   (reset),
        .load    (scan_load),
        .enable  (scan_en),
        .limit_w (limit_w),
        .limit_h (limit_h),
        .dx      (dx),
        .dy      (dy),
        .last    (scan_last)
    );

    always_comb begin
        limit_w = (state_q == ST_CLEAR) ? SCREEN_W_LIM : {{(X_W-SIZE_W){1'b0}}, w_q};
        limit_h = (state_q == ST_CLEAR) ? SCREEN_H_LIM : {{(Y_W-SIZE_W){1'b0}}, h_q};
        // One bit wider than the operands so large origins clip instead of wrapping.
        sum_x   = {1'b0, x0_q} + {1'b0, dx};
        sum_y   = {1'b0, y0_q} + {1'b0, dy};
    end

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        h_d       = h_q;
        col_d     = col_q;
        scan_load = 1'b0;
        scan_en   = 1'b0;
        plot_d    = 1'b0;
        vga_x_d   = vga_x_q;
        vga_y_d   = vga_y_q;
        vga_col_d = vga_col_q;
        busy_d    = (state_q != ST_IDLE);
        done_d    = (state_q == ST_FINISH);

        unique case (state_q)
            ST_IDLE: begin
                // The done cycle is spent in IDLE with busy still high; requests
                // arriving then are dropped like any other request while busy.
                if (!busy_q) begin
                    if (clear) begin
                        scan_load = 1'b1;
                        state_d   = ST_CLEAR;
                    end else if (start) begin
                        scan_load = 1'b1;
                        x0_d      = rect_x;
                        y0_d      = rect_y;
                        w_d       = rect_w;
                        h_d       = rect_h;
                        col_d     = rect_colour;
                        state_d   = ((rect_w == '0) || (rect_h == '0)) ? ST_FINISH : ST_DRAW;
                    end
                end
            end
            ST_DRAW: begin
                scan_en = 1'b1;
                if (in_screen(sum_x, sum_y)) begin
                    plot_d    = 1'b1;
                    vga_x_d   = sum_x[X_W-1:0];
                    vga_y_d   = sum_y[Y_W-1:0];
                    vga_col_d = col_q;
                end
                if (scan_last) begin
                    state_d = ST_FINISH;
                end
            end
            ST_CLEAR: begin
                scan_en   = 1'b1;
                plot_d    = 1'b1;
                vga_x_d   = dx;
                vga_y_d   = dy;
                vga_col_d = BG_COLOUR;
                if (scan_last) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            col_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            plot_q    <= 1'b0;
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            vga_col_q <= '0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            col_q     <= col_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            plot_q    <= plot_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            vga_col_q <= vga_col_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign plot       = plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;

endmodule

// File: tb/tb_rect_plotter.sv
module tb_rect_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       clear;
    logic [7:0] rect_x;
    logic [6:0] rect_y;
    logic [4:0] rect_w;
    logic [4:0] rect_h;
    logic [2:0] rect_colour;
    logic       busy;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;

    int checks = 0;
    int errors = 0;

    rect_plotter dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .clear       (clear),
        .rect_x      (rect_x),
        .rect_y      (rect_y),
        .rect_w      (rect_w),
        .rect_h      (rect_h),
        .rect_colour (rect_colour),
        .busy        (busy),
        .done        (done),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .plot        (plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [4:0] w;
        logic [4:0] h;
        logic [2:0] col;
        int         exp_plots;
        int         exp_done;   // cycle (after acceptance edge) on which done is high
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Issues one request and watches cycles 1 .. exp_done+1 after acceptance.
    // Operands are scrambled right after acceptance; with pulse set, start is
    // re-asserted on every busy cycle.
    task automatic run_req(input string name,
                           input logic [7:0] x, input logic [6:0] y,
                           input logic [4:0] w, input logic [4:0] h,
                           input logic [2:0] col,
                           input logic do_start, input logic do_clear,
                           input logic pulse,
                           input int exp_plots, input int exp_done);
        int plots, done_at, dones, busy_err, pix_err, bad_k;
        int mw, mh, mx, my, len, idx, px, py;
        logic exp_plot;
        logic [2:0] mc;
        logic [18:0] bad_act, bad_exp;
        plots = 0; done_at = 0; dones = 0; busy_err = 0; pix_err = 0; bad_k = -1;
        bad_act = '0; bad_exp = '0;
        mw  = do_clear ? 160 : int'(w);
        mh  = do_clear ? 120 : int'(h);
        mx  = do_clear ? 0 : int'(x);
        my  = do_clear ? 0 : int'(y);
        mc  = do_clear ? 3'b000 : col;
        len = mw * mh;

        @(negedge clk);
        rect_x = x; rect_y = y; rect_w = w; rect_h = h; rect_colour = col;
        start = do_start; clear = do_clear;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        rect_x = ~x; rect_y = ~y; rect_w = ~w; rect_h = ~h; rect_colour = ~col;

        for (int k = 1; k <= exp_done + 1; k++) begin
            @(negedge clk);
            idx = k - 1;
            exp_plot = 1'b0;
            px = 0; py = 0;
            if (idx < len) begin
                px = mx + idx % mw;
                py = my + idx / mw;
                exp_plot = (px < 160) && (py < 120);
            end
            if ((plot !== exp_plot) ||
                (exp_plot && ((vga_x !== px[7:0]) || (vga_y !== py[6:0]) || (vga_colour !== mc)))) begin
                pix_err++;
                if (bad_k < 0) begin
                    bad_k   = k;
                    bad_act = {plot, vga_x, vga_y, vga_colour};
                    bad_exp = {exp_plot, px[7:0], py[6:0], mc};
                end
            end
            if (plot === 1'b1) plots++;
            if (done === 1'b1) begin
                dones++;
                if (done_at == 0) done_at = k;
            end
            if (busy !== (k <= exp_done)) busy_err++;
            start = pulse && (busy === 1'b1);
        end
        start = 1'b0;

        checks++;
        if (pix_err != 0) begin
            errors++;
            $display("FAIL %s.pixels bad=%0d first_cycle=%0d actual={plot,x,y,col}=%h required=%h",
                     name, pix_err, bad_k, bad_act, bad_exp);
        end
        check({name, ".plot_count"}, plots, exp_plots);
        check({name, ".done_cycle"}, done_at, exp_done);
        check({name, ".done_pulses"}, dones, 1);
        check({name, ".busy_errs"}, busy_err, 0);
    endtask

    initial begin
        int dones;

        vecs[0] = '{x: 8'd10,  y: 7'd20,  w: 5'd3,  h: 5'd2,  col: 3'd5, exp_plots: 6,   exp_done: 7};
        vecs[1] = '{x: 8'd158, y: 7'd118, w: 5'd4,  h: 5'd4,  col: 3'd2, exp_plots: 4,   exp_done: 17};
        vecs[2] = '{x: 8'd30,  y: 7'd40,  w: 5'd0,  h: 5'd5,  col: 3'd1, exp_plots: 0,   exp_done: 1};
        vecs[3] = '{x: 8'd255, y: 7'd10,  w: 5'd31, h: 5'd2,  col: 3'd6, exp_plots: 0,   exp_done: 63};
        vecs[4] = '{x: 8'd0,   y: 7'd0,   w: 5'd1,  h: 5'd1,  col: 3'd7, exp_plots: 1,   exp_done: 2};
        vecs[5] = '{x: 8'd150, y: 7'd100, w: 5'd31, h: 5'd31, col: 3'd3, exp_plots: 200, exp_done: 962};
        vecs[6] = '{x: 8'd5,   y: 7'd119, w: 5'd2,  h: 5'd3,  col: 3'd4, exp_plots: 2,   exp_done: 7};
        vecs[7] = '{x: 8'd12,  y: 7'd12,  w: 5'd5,  h: 5'd0,  col: 3'd1, exp_plots: 0,   exp_done: 1};
        vecs[8] = '{x: 8'd0,   y: 7'd0,   w: 5'd31, h: 5'd1,  col: 3'd2, exp_plots: 31,  exp_done: 32};

        reset = 1'b1; start = 1'b0; clear = 1'b0;
        rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; rect_colour = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.plot", plot, 0);
        check("reset.vga_x", vga_x, 0);
        check("reset.vga_y", vga_y, 0);
        check("reset.vga_colour", vga_colour, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h,
                    vecs[i].col, 1'b1, 1'b0, 1'b0, vecs[i].exp_plots, vecs[i].exp_done);
        end

        // Last plotted pixel is held once plot drops.
        run_req("hold", 8'd10, 7'd20, 5'd3, 5'd2, 3'd5, 1'b1, 1'b0, 1'b0, 6, 7);
        check("hold.vga_x", vga_x, 12);
        check("hold.vga_y", vga_y, 21);
        check("hold.vga_colour", vga_colour, 5);
        check("hold.plot", plot, 0);

        // Start pulses while busy are ignored.
        run_req("pulse", 8'd20, 7'd30, 5'd4, 5'd3, 3'd6, 1'b1, 1'b0, 1'b1, 12, 13);

        // Clear and start together: clear wins, full-screen fill.
        run_req("clear", 8'd10, 7'd20, 5'd3, 5'd2, 3'd5, 1'b1, 1'b1, 1'b0, 19200, 19201);
        check("clear.last_x", vga_x, 159);
        check("clear.last_y", vga_y, 119);
        check("clear.colour", vga_colour, 0);

        // Reset mid-draw after three pixels.
        @(negedge clk);
        rect_x = 8'd40; rect_y = 7'd50; rect_w = 5'd5; rect_h = 5'd4; rect_colour = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset.pre_plot", plot, 1);
        check("midreset.pre_x", vga_x, 42);
        #2 reset = 1'b1;
        #1;
        check("midreset.plot", plot, 0);
        check("midreset.busy", busy, 0);
        check("midreset.vga_x", vga_x, 0);
        check("midreset.vga_y", vga_y, 0);
        check("midreset.vga_colour", vga_colour, 0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("midreset.no_done", dones, 0);
        run_req("after_reset", 8'd40, 7'd50, 5'd5, 5'd4, 3'd2, 1'b1, 1'b0, 1'b0, 20, 21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
